// File: rtl/clk_period_meter.sv
// clk_period_meter: measures slow_clk period/high time in clk_in cycles with lock and timeout status.
// Define PERIOD_METER_DUTY_EN to enable high_time measurement; otherwise high_time is tied to 0.
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             timeout
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  logic [SYNC_STAGES-1:0] sync;
  logic [0:0] state;
  logic s, s_d, rise, first;
  logic [CNT_W-1:0] cnt, cnt_inc;
  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign cnt_inc = cnt + 1'b1;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync         <= '0;
      s_d          <= 1'b0;
      rise_pulse   <= 1'b0;
      period_valid <= 1'b0;
      period       <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      first        <= 1'b0;
      cnt          <= '0;
      state        <= IDLE;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], slow_clk};
      s_d          <= s;
      rise_pulse   <= rise;
      period_valid <= 1'b0;
      cnt          <= rise ? '0 : (&cnt ? cnt : cnt_inc);
      if (state == IDLE) begin
        if (rise) begin
          state   <= MEASURE;
          timeout <= 1'b0;
          first   <= 1'b1;
        end
      end else if (rise) begin
        // first update after arming has no valid previous period to compare
        period       <= cnt_inc;
        period_valid <= 1'b1;
        locked       <= !first && cnt_inc == period && cnt_inc != '0;
        first        <= 1'b0;
      end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
        state   <= IDLE;
        timeout <= 1'b1;
        locked  <= 1'b0;
      end
    end
  end
`ifdef PERIOD_METER_DUTY_EN
  logic fall;
  assign fall = ~s & s_d;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) high_time <= '0;
    else if (state == MEASURE && fall) high_time <= cnt_inc;
  end
`else
  assign high_time = '0;
`endif
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed self-checking bench for clk_period_meter (TIMEOUT=100).
module tb_clk_period_meter;
  localparam int CNT_W = 16;
`ifdef PERIOD_METER_DUTY_EN
  localparam int EXP_HIGH = 5;
`else
  localparam int EXP_HIGH = 0;
`endif
  logic clk_in = 1'b0, rst = 1'b1, slow_clk;
  logic rise_pulse, period_valid, locked, timeout;
  logic [CNT_W-1:0] period, high_time;
  int checks = 0, failures = 0;
  int run = 0, per = 10, hi = 5;
  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(100), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .rise_pulse(rise_pulse),
    .period(period), .period_valid(period_valid), .high_time(high_time),
    .locked(locked), .timeout(timeout)
  );
  always #5 clk_in = ~clk_in;
  // slow_clk generator: changes on negedge; new per/hi taken at period start
  initial begin
    int ph, cper, chi;
    ph = 0; cper = 10; chi = 5;
    slow_clk = 1'b0;
    forever begin
      @(negedge clk_in);
      if (run == 0) begin
        slow_clk = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0) begin cper = per; chi = hi; end
        slow_clk = ph < chi;
        ph = (ph + 1 == cper) ? 0 : ph + 1;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_rise(input string tag);
    int n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (rise_pulse !== 1'b1 && n < 300);
    check({tag, "_rise"}, {31'b0, rise_pulse}, 1);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, {16'b0, period}, 0);
    check({tag, "_valid"}, {31'b0, period_valid}, 0);
    check({tag, "_locked"}, {31'b0, locked}, 0);
    check({tag, "_timeout"}, {31'b0, timeout}, 0);
    check({tag, "_high"}, {16'b0, high_time}, 0);
    check({tag, "_pulse"}, {31'b0, rise_pulse}, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk_in);
    #1 check_all_zero("reset");
    @(negedge clk_in) rst = 1'b0;
    // test 1: period 10, 50% duty
    run = 1;
    wait_rise("t1r1");
    check("t1r1_valid", {31'b0, period_valid}, 0);
    check("t1r1_period", {16'b0, period}, 0);
    wait_rise("t1r2");
    check("t1r2_valid", {31'b0, period_valid}, 1);
    check("t1r2_period", {16'b0, period}, 10);
    check("t1r2_locked", {31'b0, locked}, 0);
    wait_rise("t1r3");
    check("t1r3_valid", {31'b0, period_valid}, 1);
    check("t1r3_period", {16'b0, period}, 10);
    check("t1r3_locked", {31'b0, locked}, 1);
    check("t1r3_high", {16'b0, high_time}, EXP_HIGH);
    @(posedge clk_in); #1;
    check("t1_valid_drop", {31'b0, period_valid}, 0);
    // test 2: switch to period 8 (takes effect after the current slow cycle)
    per = 8; hi = 4;
    wait_rise("t2r0");
    check("t2r0_period", {16'b0, period}, 10);
    check("t2r0_locked", {31'b0, locked}, 1);
    wait_rise("t2r1");
    check("t2r1_period", {16'b0, period}, 8);
    check("t2r1_locked", {31'b0, locked}, 0);
    wait_rise("t2r2");
    check("t2r2_period", {16'b0, period}, 8);
    check("t2r2_locked", {31'b0, locked}, 1);
    // test 3: stop slow_clk, timeout exactly 100 cycles after cnt clear
    run = 0;
    repeat (99) @(posedge clk_in);
    #1 check("t3_pre_timeout", {31'b0, timeout}, 0);
    check("t3_pre_locked", {31'b0, locked}, 1);
    @(posedge clk_in); #1;
    check("t3_timeout", {31'b0, timeout}, 1);
    check("t3_locked", {31'b0, locked}, 0);
    check("t3_period_hold", {16'b0, period}, 8);
    per = 10; hi = 5; run = 1;
    wait_rise("t3r1");
    check("t3r1_valid", {31'b0, period_valid}, 0);
    check("t3r1_timeout", {31'b0, timeout}, 0);
    wait_rise("t3r2");
    check("t3r2_valid", {31'b0, period_valid}, 1);
    check("t3r2_period", {16'b0, period}, 10);
    check("t3r2_locked", {31'b0, locked}, 0);
    wait_rise("t3r3");
    check("t3r3_locked", {31'b0, locked}, 1);
    // test 4: async reset mid-period while locked
    repeat (4) @(posedge clk_in);
    #1 rst = 1'b1;
    #1 check_all_zero("t4_rst");
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst = 1'b0;
    wait_rise("t4r1");
    check("t4r1_valid", {31'b0, period_valid}, 0);
    check("t4r1_period", {16'b0, period}, 0);
    // test 5: fastest input, toggling every clk_in cycle
    run = 0;
    repeat (120) @(posedge clk_in);
    #1 check("t5_idle_timeout", {31'b0, timeout}, 1);
    per = 2; hi = 1; run = 1;
    wait_rise("t5r1");
    check("t5r1_valid", {31'b0, period_valid}, 0);
    check("t5r1_timeout", {31'b0, timeout}, 0);
    wait_rise("t5r2");
    check("t5r2_period", {16'b0, period}, 2);
    check("t5r2_locked", {31'b0, locked}, 0);
    wait_rise("t5r3");
    check("t5r3_period", {16'b0, period}, 2);
    check("t5r3_locked", {31'b0, locked}, 1);
    wait_rise("t5r4");
    check("t5r4_valid", {31'b0, period_valid}, 1);
    check("t5r4_locked", {31'b0, locked}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
